dht11_sensor_emu: RTL and testbench
===================================

# dht11_sensor_emu

Single-wire DHT11 sensor emulator: the responder end of the DHT11 protocol. It waits for a host start pulse on the open-drain data line, then answers with the standard acknowledge sequence and a 40-bit frame: humidity int/frac, temperature int/frac, checksum. It serves as an on-FPGA loopback target and bench stimulus for the DHT11 host reader. Frame contents come from register inputs that are latched at start acceptance.

## Interface
Parameters (cycle counts at 50 MHz):
- T_START_MIN, 50000: minimum host low time accepted as a start (1 ms)
- T_RESP_DLY, 1500: bus-released delay before acknowledge (30 us)
- T_ACK_LOW, 4000: acknowledge low phase (80 us)
- T_ACK_HIGH, 4000: acknowledge high phase (80 us)
- T_BIT_LOW, 2500: low phase preceding every bit and trailing end marker (50 us)
- T_ZERO_HIGH, 1300: high phase for a '0' (26 us)
- T_ONE_HIGH, 3500: high phase for a '1' (70 us)

Ports:
- CLK  in  1  system clock
- RST  in  1  reset, synchronous, active-high; priority over all other inputs including EN
- EN  in  1  enable; low aborts any transfer and holds the block in IDLE
- DHT_DATA  inout  1  open-drain bus; driven 0 or Z only, never 1
- HUM_INT, HUM_FLOAT, TEMP_INT, TEMP_FLOAT  in  8 each  frame payload
- BUSY  out  1  high from start acceptance until the end marker completes
- DONE  out  1  one-cycle pulse when the frame completes
- START_ERR  out  1  one-cycle pulse when a host low pulse is shorter than T_START_MIN
- CRC_OUT  out  8  checksum of the last latched frame

## Operation
- Bus input passes through a 2-flop synchronizer. Released bus (Z) reads 1 via external or bench pull-up.
- Bus output is a registered DRV_LOW flag; DHT_DATA = DRV_LOW ? 0 : Z.
- Checksum: (HUM_INT + HUM_FLOAT + TEMP_INT + TEMP_FLOAT) mod 256, computed with a 10-bit sum truncated to 8 bits.
- Frame order: HUM_INT, HUM_FLOAT, TEMP_INT, TEMP_FLOAT, CRC; MSB first within each byte. This gives 40 bits, indexed 39 down to 0.
- FSM:
  - IDLE: DRV_LOW=0. A synced low moves to HOST_LOW with the counter cleared.
  - HOST_LOW: count while synced low. On synced high:
    - If count >= T_START_MIN: latch the payload into a 40-bit shift register, set BUSY, go to RESP_DLY.
    - Otherwise: pulse START_ERR and go to IDLE.
    - The counter saturates; it does not wrap.
  - RESP_DLY: T_RESP_DLY cycles released, then ACK_LOW.
  - ACK_LOW: T_ACK_LOW cycles driven low, then ACK_HIGH.
  - ACK_HIGH: T_ACK_HIGH cycles released, then BIT_LOW with bit index 39.
  - BIT_LOW: T_BIT_LOW cycles driven low, then BIT_HIGH.
  - BIT_HIGH: released for T_ONE_HIGH cycles if the current bit is 1, T_ZERO_HIGH if 0. Then shift; if index was 0 go to END_LOW, else decrement and go to BIT_LOW.
  - END_LOW: T_BIT_LOW cycles driven low, then release. Pulse DONE, clear BUSY, go to IDLE.
- The bus is not monitored from RESP_DLY through END_LOW. Host activity during a frame is ignored.
- Payload input changes after latching do not affect the frame in flight.
- EN=0 in any state: next cycle DRV_LOW=0, BUSY=0, state IDLE, counter cleared, no DONE.
- RST: same as EN=0. Additionally CRC_OUT=0 and the shift register is cleared.

## Timing
- Reset values: DHT_DATA=Z, BUSY=0, DONE=0, START_ERR=0, CRC_OUT=0.
- Start acceptance occurs 2 cycles (synchronizer) + 1 cycle after the host releases the bus.
- Each phase lasts exactly its parameter count in cycles, measured on DHT_DATA, with no ±1 slack.
- Frame duration from acceptance to DONE: T_RESP_DLY + T_ACK_LOW + T_ACK_HIGH + 41*T_BIT_LOW + n1*T_ONE_HIGH + (40-n1)*T_ZERO_HIGH, where n1 is the count of '1' bits.
- DONE is asserted in the cycle DRV_LOW falls to 0 after END_LOW.
- START_ERR is asserted in the cycle after the synced rising edge.

## Configuration
- DHT_EMU_CRC_INJ_EN defined: adds input CRC_INJ (1 bit), sampled at start acceptance. When high, the transmitted checksum and CRC_OUT are the computed value XOR 8'h01, for host error-path testing.
- Undefined: the port is absent and the checksum is always correct.

## Test plan
- Host low 60000 cycles then release, payload 37/00/19/00 hex: release 1500, low 4000, high 4000; 40 bits with high widths 1300/3500 per bit; CRC 8'h50; DONE once; BUSY low afterwards.
- Host low 10000 cycles: START_ERR single pulse, DHT_DATA stays Z, BUSY stays 0.
- Payload FF/FF/01/02: CRC_OUT = 8'h01 and the last 8 bits on the wire are 00000001.
- Change all payload inputs during bit 20: the transmitted bytes equal the values latched at acceptance.
- Assert RST (and separately EN=0) during BIT_LOW of bit 10: DHT_DATA is Z next cycle, BUSY=0, no DONE; a subsequent valid start produces a full frame.
- With DHT_EMU_CRC_INJ_EN, CRC_INJ=1, payload 37/00/19/00: CRC 8'h51 transmitted.

Source files
------------

// File: rtl/dht11_sensor_emu.sv
// DHT11 responder: answers a host start pulse with ack and a 40-bit frame on an open-drain line.
// Optional DHT_EMU_CRC_INJ_EN adds CRC_INJ, which flips checksum bit 0 for host error-path testing.
module dht11_sensor_emu #(
  parameter int unsigned T_START_MIN = 50000,
  parameter int unsigned T_RESP_DLY  = 1500,
  parameter int unsigned T_ACK_LOW   = 4000,
  parameter int unsigned T_ACK_HIGH  = 4000,
  parameter int unsigned T_BIT_LOW   = 2500,
  parameter int unsigned T_ZERO_HIGH = 1300,
  parameter int unsigned T_ONE_HIGH  = 3500
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  inout  wire        DHT_DATA,
  input  logic [7:0] HUM_INT,
  input  logic [7:0] HUM_FLOAT,
  input  logic [7:0] TEMP_INT,
  input  logic [7:0] TEMP_FLOAT,
`ifdef DHT_EMU_CRC_INJ_EN
  input  logic       CRC_INJ,
`endif
  output logic       BUSY,
  output logic       DONE,
  output logic       START_ERR,
  output logic [7:0] CRC_OUT
);

  localparam int unsigned M0 = (T_START_MIN > T_RESP_DLY) ? T_START_MIN : T_RESP_DLY;
  localparam int unsigned M1 = (T_ACK_LOW > T_ACK_HIGH) ? T_ACK_LOW : T_ACK_HIGH;
  localparam int unsigned M2 = (T_ZERO_HIGH > T_ONE_HIGH) ? T_ZERO_HIGH : T_ONE_HIGH;
  localparam int unsigned M3 = (M0 > M1) ? M0 : M1;
  localparam int unsigned M4 = (M2 > T_BIT_LOW) ? M2 : T_BIT_LOW;
  localparam int unsigned MAXT = (M3 > M4) ? M3 : M4;
  localparam int unsigned CW = $clog2(MAXT + 1);

  typedef enum logic [2:0] {
    IDLE, HOST_LOW, RESP_DLY, ACK_LOW, ACK_HIGH, BIT_LOW, BIT_HIGH, END_LOW
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [39:0]   shreg;
  logic [5:0]    bit_idx;
  logic          drv_low;
  logic [1:0]    sync;
  logic          bus_in;
  logic          crc_inj_bit;
  logic [9:0]    sum;
  logic [7:0]    crc_calc;
  logic [CW-1:0] high_last;

`ifdef DHT_EMU_CRC_INJ_EN
  assign crc_inj_bit = CRC_INJ;
`else
  assign crc_inj_bit = 1'b0;
`endif

  assign sum       = {2'b00, HUM_INT} + {2'b00, HUM_FLOAT} + {2'b00, TEMP_INT} + {2'b00, TEMP_FLOAT};
  assign crc_calc  = 8'(sum) ^ {7'b0, crc_inj_bit};
  assign high_last = shreg[39] ? CW'(T_ONE_HIGH - 1) : CW'(T_ZERO_HIGH - 1);
  assign bus_in    = sync[1];
  assign DHT_DATA  = drv_low ? 1'b0 : 1'bz;

  // Released bus reads high, so the synchronizer resets to 1 to avoid a false start.
  always_ff @(posedge CLK) begin
    if (RST) sync <= 2'b11;
    else     sync <= {sync[0], DHT_DATA};
  end

  // Every timed phase counts 0..T-1; drv_low changes on the same edge as the state,
  // so each level on the wire lasts exactly its parameter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      bit_idx   <= '0;
      drv_low   <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      START_ERR <= 1'b0;
      CRC_OUT   <= '0;
    end else if (!EN) begin
      state     <= IDLE;
      cnt       <= '0;
      drv_low   <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      START_ERR <= 1'b0;
    end else begin
      DONE      <= 1'b0;
      START_ERR <= 1'b0;
      case (state)
        IDLE: begin
          drv_low <= 1'b0;
          if (!bus_in) begin
            state <= HOST_LOW;
            cnt   <= '0;
          end
        end
        HOST_LOW: begin
          if (!bus_in) begin
            if (cnt != {CW{1'b1}}) cnt <= cnt + CW'(1);
          end else if (cnt >= CW'(T_START_MIN)) begin
            shreg   <= {HUM_INT, HUM_FLOAT, TEMP_INT, TEMP_FLOAT, crc_calc};
            CRC_OUT <= crc_calc;
            BUSY    <= 1'b1;
            cnt     <= '0;
            state   <= RESP_DLY;
          end else begin
            START_ERR <= 1'b1;
            state     <= IDLE;
          end
        end
        RESP_DLY: begin
          if (cnt == CW'(T_RESP_DLY - 1)) begin
            cnt     <= '0;
            drv_low <= 1'b1;
            state   <= ACK_LOW;
          end else cnt <= cnt + CW'(1);
        end
        ACK_LOW: begin
          if (cnt == CW'(T_ACK_LOW - 1)) begin
            cnt     <= '0;
            drv_low <= 1'b0;
            state   <= ACK_HIGH;
          end else cnt <= cnt + CW'(1);
        end
        ACK_HIGH: begin
          if (cnt == CW'(T_ACK_HIGH - 1)) begin
            cnt     <= '0;
            drv_low <= 1'b1;
            bit_idx <= 6'd39;
            state   <= BIT_LOW;
          end else cnt <= cnt + CW'(1);
        end
        BIT_LOW: begin
          if (cnt == CW'(T_BIT_LOW - 1)) begin
            cnt     <= '0;
            drv_low <= 1'b0;
            state   <= BIT_HIGH;
          end else cnt <= cnt + CW'(1);
        end
        BIT_HIGH: begin
          if (cnt == high_last) begin
            cnt     <= '0;
            drv_low <= 1'b1;
            shreg   <= {shreg[38:0], 1'b0};
            if (bit_idx == 6'd0) state <= END_LOW;
            else begin
              bit_idx <= bit_idx - 6'd1;
              state   <= BIT_LOW;
            end
          end else cnt <= cnt + CW'(1);
        end
        END_LOW: begin
          if (cnt == CW'(T_BIT_LOW - 1)) begin
            cnt     <= '0;
            drv_low <= 1'b0;
            DONE    <= 1'b1;
            BUSY    <= 1'b0;
            state   <= IDLE;
          end else cnt <= cnt + CW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dht11_sensor_emu.sv
// Bench for dht11_sensor_emu: host start pulses, expected wire phases queued per frame and
// compared run-by-run; also covers short pulses, mid-frame payload change, RST and EN aborts.
module tb_dht11_sensor_emu;

  localparam int TS  = 50;
  localparam int TR  = 15;
  localparam int TAL = 40;
  localparam int TAH = 44;
  localparam int TBL = 25;
  localparam int TZ  = 13;
  localparam int TO  = 35;

  logic       clock = 1'b0;
  logic       rst;
  logic       en;
  logic       hostLow;
  logic [7:0] humInt, humFloat, tempInt, tempFloat;
`ifdef DHT_EMU_CRC_INJ_EN
  logic       crcInj;
`endif
  logic       busy, done, startErr;
  logic [7:0] crcOut;
  wire        dhtData;

  assign dhtData = hostLow ? 1'b0 : 1'bz;
  pullup (dhtData);

  dht11_sensor_emu #(
    .T_START_MIN(TS), .T_RESP_DLY(TR), .T_ACK_LOW(TAL), .T_ACK_HIGH(TAH),
    .T_BIT_LOW(TBL), .T_ZERO_HIGH(TZ), .T_ONE_HIGH(TO)
  ) dut (
    .CLK(clock), .RST(rst), .EN(en), .DHT_DATA(dhtData),
    .HUM_INT(humInt), .HUM_FLOAT(humFloat), .TEMP_INT(tempInt), .TEMP_FLOAT(tempFloat),
`ifdef DHT_EMU_CRC_INJ_EN
    .CRC_INJ(crcInj),
`endif
    .BUSY(busy), .DONE(done), .START_ERR(startErr), .CRC_OUT(crcOut)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] hi, hf, ti, tf;
    logic       inj;
    logic [7:0] crc;
  } vec_t;

  typedef struct {
    logic lvl;
    int   len;
  } run_t;

  vec_t vecs[$];
  run_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic hostPulse(input int n);
    @(negedge clock);
    hostLow = 1'b1;
    repeat (n) @(negedge clock);
    hostLow = 1'b0;
  endtask

  // Expected wire runs are derived from the payload bytes and the table's checksum.
  task automatic pushFrame(input vec_t v);
    logic [39:0] f;
    f = {v.hi, v.hf, v.ti, v.tf, v.crc};
    expQ.push_back('{1'b1, TR});
    expQ.push_back('{1'b0, TAL});
    expQ.push_back('{1'b1, TAH});
    for (int i = 39; i >= 0; i--) begin
      expQ.push_back('{1'b0, TBL});
      expQ.push_back('{1'b1, f[i] ? TO : TZ});
    end
    expQ.push_back('{1'b0, TBL});
  endtask

  task automatic applyStimulus(input vec_t v);
    humInt = v.hi; humFloat = v.hf; tempInt = v.ti; tempFloat = v.tf;
`ifdef DHT_EMU_CRC_INJ_EN
    crcInj = v.inj;
`endif
    pushFrame(v);
    hostPulse(60);
  endtask

  task automatic emitRun(input logic lvl, input int len);
    run_t e;
    if (expQ.size() == 0) begin
      checkOutput("extra_run", 32'(len), 32'd0);
    end else begin
      e = expQ.pop_front();
      checkOutput("run_level", {31'd0, lvl}, {31'd0, e.lvl});
      checkOutput("run_len", 32'(len), 32'(e.len));
    end
  endtask

  // kind: 0 plain, 1 change payload, 2 RST abort, 3 EN abort; acted on in low run of sent bit k.
  task automatic captureFrame(input int k, input int kind);
    int   budget, len, runIdx, doneSeen, lows, dones;
    logic cur, lvl;
    budget = 0;
    while (busy !== 1'b1 && budget < 100) begin
      @(negedge clock);
      budget++;
    end
    checkOutput("busy_rise", {31'd0, busy}, 32'd1);
    if (busy !== 1'b1) begin
      expQ.delete();
      return;
    end
    cur = dhtData; len = 1; runIdx = 0; doneSeen = 0; budget = 0;
    while (budget < 5000) begin
      @(negedge clock);
      budget++;
      if (done === 1'b1) doneSeen++;
      lvl = dhtData;
      if (lvl === cur) len++;
      else begin
        emitRun(cur, len);
        runIdx++;
        cur = lvl;
        len = 1;
      end
      if (done === 1'b1) break;
      if (kind != 0 && runIdx == 3 + 2 * k && cur == 1'b0 && len == 5) begin
        if (kind == 1) begin
          humInt = 8'($urandom); humFloat = 8'($urandom);
          tempInt = 8'($urandom); tempFloat = 8'($urandom);
        end else begin
          if (kind == 2) rst = 1'b1; else en = 1'b0;
          @(posedge clock);
          #1;
          checkOutput("abort_bus", {31'd0, dhtData}, 32'd1);
          checkOutput("abort_busy", {31'd0, busy}, 32'd0);
          checkOutput("abort_done", {31'd0, done}, 32'd0);
          @(negedge clock);
          rst = 1'b0;
          en  = 1'b1;
          if (kind == 2) checkOutput("rst_crc_clear", {24'd0, crcOut}, 32'd0);
          expQ.delete();
          lows = 0; dones = 0;
          repeat (100) begin
            @(negedge clock);
            if (dhtData !== 1'b1) lows++;
            if (done !== 1'b0) dones++;
          end
          checkOutput("abort_quiet_bus", 32'(lows), 32'd0);
          checkOutput("abort_no_done", 32'(dones), 32'd0);
          return;
        end
      end
    end
    checkOutput("done_seen", 32'(doneSeen), 32'd1);
    checkOutput("busy_at_done", {31'd0, busy}, 32'd0);
    @(negedge clock);
    checkOutput("done_single", {31'd0, done}, 32'd0);
    checkOutput("runs_left", 32'(expQ.size()), 32'd0);
    expQ.delete();
  endtask

  initial begin
    int errCnt, busyCnt, lowCnt;
    vecs.push_back('{8'h37, 8'h00, 8'h19, 8'h00, 1'b0, 8'h50});
    vecs.push_back('{8'hFF, 8'hFF, 8'h01, 8'h02, 1'b0, 8'h01});
    vecs.push_back('{8'h12, 8'h34, 8'h56, 8'h78, 1'b0, 8'h14});
    vecs.push_back('{8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00});
`ifdef DHT_EMU_CRC_INJ_EN
    vecs.push_back('{8'h37, 8'h00, 8'h19, 8'h00, 1'b1, 8'h51});
    crcInj = 1'b0;
`endif
    rst = 1'b1; en = 1'b1; hostLow = 1'b0;
    humInt = 8'h00; humFloat = 8'h00; tempInt = 8'h00; tempFloat = 8'h00;
    repeat (4) @(negedge clock);
    checkOutput("reset_bus", {31'd0, dhtData}, 32'd1);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_start_err", {31'd0, startErr}, 32'd0);
    checkOutput("reset_crc", {24'd0, crcOut}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clock);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      captureFrame(0, 0);
      checkOutput("crc_out", {24'd0, crcOut}, {24'd0, vecs[i].crc});
      repeat (10) @(negedge clock);
    end

    hostPulse(10);
    errCnt = 0; busyCnt = 0; lowCnt = 0;
    repeat (25) begin
      @(negedge clock);
      if (startErr === 1'b1) errCnt++;
      if (busy !== 1'b0) busyCnt++;
      if (dhtData !== 1'b1) lowCnt++;
    end
    checkOutput("short_start_err", 32'(errCnt), 32'd1);
    checkOutput("short_busy", 32'(busyCnt), 32'd0);
    checkOutput("short_bus", 32'(lowCnt), 32'd0);

    applyStimulus(vecs[0]);
    captureFrame(19, 1);
    checkOutput("latched_crc", {24'd0, crcOut}, 32'h50);
    repeat (10) @(negedge clock);

    applyStimulus(vecs[0]);
    captureFrame(29, 2);
    applyStimulus(vecs[1]);
    captureFrame(0, 0);
    checkOutput("after_rst_crc", {24'd0, crcOut}, 32'h01);
    repeat (10) @(negedge clock);

    applyStimulus(vecs[2]);
    captureFrame(29, 3);
    checkOutput("after_en_crc", {24'd0, crcOut}, 32'h14);
    applyStimulus(vecs[0]);
    captureFrame(0, 0);
    checkOutput("after_en_frame_crc", {24'd0, crcOut}, 32'h50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #700000;
    $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

endmodule
